// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op at a time to the ALU, holds operands for the op latency, captures the result
module alu_op_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 64,
    parameter int ALU_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done
);
    localparam int CW = $clog2(MULT_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] ALU_LOAD  = CW'(ALU_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HOLD, CAPTURE} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
    logic             zero_q, done_q;
    assign ready  = (state_q == IDLE);
    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;
    // Issue/hold/capture FSM; operands latch only on an accepted start and stay put until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    alu_op_q <= op_in;
                    alu_a_q  <= a_in;
                    alu_b_q  <= b_in;
                    cnt_q    <= (op_in == 3'b011) ? MULT_LOAD : ALU_LOAD;
                    state_q  <= HOLD;
                end
                HOLD: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                      else state_q <= CAPTURE;
                CAPTURE: begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of issue, hold, capture, busy-ignore, back-to-back and async reset
module tb_alu_op_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0]  op_in = '0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        ready, zero, done;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_res, result;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    // Reference ALU feeding the sequencer
    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a ^ alu_b;
            3'b010: alu_res = alu_a - alu_b;
            3'b011: alu_res = alu_a * alu_b;
            3'b100: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b101: alu_res = ~(alu_a | alu_b);
            3'b110: alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end
    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .ready(ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .result(result), .zero(zero), .done(done)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input bit noise, input logic [31:0] exp_res);
        int lat = 0, busy = 0, moved = 0;
        @(negedge clk);
        op_in = op; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 200) begin
            if (!ready) busy++;
            if (alu_a !== a || alu_b !== b || alu_op !== op) moved++;
            if (noise) begin
                start = lat[0];
                a_in  = $urandom;
                b_in  = $urandom;
                op_in = 3'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, n + 1);
        check({tag, " busy"}, busy, n + 1);
        check({tag, " hold"}, moved, 0);
        check({tag, " result"}, result, exp_res);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_res == 0});
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, ready}, 32'd1);
    endtask
    initial begin
        int acc, dn;
        #12;
        check("rst ready", {31'd0, ready}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        check("rst alu_op", {29'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add", 3'b000, 32'd13, 32'd12, 1, 1'b0, 32'd25);
        run_op("mult", 3'b011, 32'd15, 32'd3, 64, 1'b1, 32'd45);
        run_op("sub", 3'b010, 32'd13, 32'd7, 1, 1'b0, 32'd6);
        run_op("slt", 3'b100, 32'h0200000D, 32'h2200000C, 1, 1'b0, 32'd1);
        run_op("subz", 3'b010, 32'd5, 32'd5, 1, 1'b0, 32'd0);
        run_op("nor", 3'b101, 32'hF0F0_0000, 32'h0F0F_0000, 1, 1'b1, 32'h0000_FFFF);
        acc = 0;
        dn  = 0;
        @(negedge clk);
        op_in = 3'b000; a_in = 32'd1; b_in = 32'd2; start = 1'b1;
        repeat (12) begin
            if (ready) acc++;
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("b2b dones", dn, acc);
        check("b2b issued", {31'd0, acc >= 3}, 32'd1);
        check("b2b result", result, 32'd3);
        @(negedge clk);
        op_in = 3'b011; a_in = 32'd15; b_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-rst busy", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst ready", {31'd0, ready}, 32'd1);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst alu_op", {29'd0, alu_op}, 32'd0);
        check("midrst alu_a", alu_a, 32'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst no_done", dn, 0);
        check("midrst result_kept", result, 32'd0);
        run_op("post-rst add", 3'b000, 32'd13, 32'd12, 1, 1'b0, 32'd25);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
